lcd_driver: RTL and testbench

LCD_DRIVER -- requirements
Module: lcd_driver

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_delay_timer.sv | 31 +++
 rtl/lcd_driver.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD driver: FSM encoding,
// init command bytes, nominal delays and the ns-to-cycles helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        INIT      = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        E_HIGH    = 3'd4,
        NIB_GAP   = 3'd5,
        POST_WAIT = 3'd6
    } lcd_state_t;

    // Init command bytes
    localparam logic [7:0] CMD_WAKE     = 8'h30;
    localparam logic [7:0] CMD_NIB4     = 8'h20;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    // Function-set opcode; DL (bit 4) and N (bit 3) are ORed in
    localparam logic [7:0] FS_BASE      = 8'h20;

    // Nominal delays in nanoseconds
    localparam int T_SU_NS    = 50;
    localparam int T_EH_NS    = 250;
    localparam int T_NIB_NS   = 1000;
    localparam int T_CHR_NS   = 40000;
    localparam int T_CMD_NS   = 40000;
    localparam int T_LONG_NS  = 2000000;
    localparam int T_INIT1_NS = 5000000;
    localparam int T_INIT2_NS = 200000;

    // ceil(ns * clk_hz / 1e9), never less than one cycle
    function automatic logic [31:0] cycles_for(input logic [63:0] ns, input logic [63:0] clk_hz);
        logic [63:0] c;
        c = (ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) c = 64'd1;
        return c[31:0];
    endfunction

    function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Load/count-down delay timer. A load of N makes done assert in the
// N-th cycle counted from the load cycle itself, so a state that loads
// on entry lasts exactly N cycles.
module lcd_delay_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             internal_reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] remaining;

    assign remaining = load ? load_val : cnt;
    assign done      = (remaining == CNT_W'(1));

    // Count down towards zero and park there until the next load
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            cnt <= '0;
        end else if (remaining != '0) begin
            cnt <= remaining - CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/lcd_driver.sv
// Character LCD write driver: power-up wait, 4/8-bit init sequence,
// then single-byte transfers with per-command post delays.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BUS_WIDTH    = 8,
    parameter int NUM_LINES    = 2,
    parameter int T_POWERUP_US = 100000
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic [8:0] d_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       busy_flag,
    output logic       rs,
    output logic       e,
    output logic [7:0] d
);

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_bus_width
        $error("lcd_driver: BUS_WIDTH must be 4 or 8");
    end

    localparam int unsigned C_SU    = cycles_for(64'(T_SU_NS), 64'(CLK_FREQ));
    localparam int unsigned C_EH    = cycles_for(64'(T_EH_NS), 64'(CLK_FREQ));
    localparam int unsigned C_NIB   = cycles_for(64'(T_NIB_NS), 64'(CLK_FREQ));
    localparam int unsigned C_CHR   = cycles_for(64'(T_CHR_NS), 64'(CLK_FREQ));
    localparam int unsigned C_CMD   = cycles_for(64'(T_CMD_NS), 64'(CLK_FREQ));
    localparam int unsigned C_LONG  = cycles_for(64'(T_LONG_NS), 64'(CLK_FREQ));
    localparam int unsigned C_INIT1 = cycles_for(64'(T_INIT1_NS), 64'(CLK_FREQ));
    localparam int unsigned C_INIT2 = cycles_for(64'(T_INIT2_NS), 64'(CLK_FREQ));
    localparam int unsigned C_PWR   = cycles_for(64'(T_POWERUP_US) * 64'd1000, 64'(CLK_FREQ));
    localparam int unsigned C_MAX   = max_u(max_u(max_u(C_PWR, C_INIT1), max_u(C_LONG, C_INIT2)),
                                            max_u(max_u(C_CHR, C_CMD), max_u(C_NIB, max_u(C_SU, C_EH))));
    localparam int          CNT_W   = $clog2(C_MAX + 1);

    localparam logic [7:0] FUNC_SET = FS_BASE
                                    | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00)
                                    | ((NUM_LINES == 2) ? 8'h08 : 8'h00);

    lcd_state_t       state;
    logic [3:0]       step;
    logic             init_active;
    logic [7:0]       cur_byte;
    logic             two_nib;
    logic             low_phase;
    logic [CNT_W-1:0] post_val;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    // Wait after a byte: clear/home are slow, everything else is short
    function automatic logic [CNT_W-1:0] post_cycles(input logic is_char, input logic [7:0] b);
        if (is_char)               return CNT_W'(C_CHR);
        else if (b[7:2] == 6'd0)   return CNT_W'(C_LONG);
        else                       return CNT_W'(C_CMD);
    endfunction

    // Init item table: steps 0-2 wake-up, 3 the 4-bit switch nibble, 4-8 commands
    function automatic logic [7:0] init_byte(input logic [3:0] s);
        case (s)
            4'd0, 4'd1, 4'd2: return CMD_WAKE;
            4'd3:             return CMD_NIB4;
            4'd4:             return FUNC_SET;
            4'd5:             return CMD_DISP_OFF;
            4'd6:             return CMD_CLEAR;
            4'd7:             return CMD_ENTRY;
            default:          return CMD_DISP_ON;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_wait(input logic [3:0] s);
        case (s)
            4'd0:       return CNT_W'(C_INIT1);
            4'd1, 4'd2: return CNT_W'(C_INIT2);
            4'd3:       return CNT_W'(C_CMD);
            default:    return post_cycles(1'b0, init_byte(s));
        endcase
    endfunction

    // First (or only) bus value of a byte; 4-bit mode sends the high nibble on d[7:4]
    function automatic logic [7:0] hi_drive(input logic [7:0] b);
        return (BUS_WIDTH == 8) ? b : {b[7:4], 4'h0};
    endfunction

    lcd_delay_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock          (clock),
        .internal_reset (internal_reset),
        .load           (tmr_load),
        .load_val       (tmr_val),
        .done           (tmr_done)
    );

    // Sequencer: every state entry reloads the timer with that state's duration
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state       <= PWR_WAIT;
            e           <= 1'b0;
            rs          <= 1'b0;
            d           <= 8'h00;
            busy_flag   <= 1'b1;
            data_ready  <= 1'b0;
            step        <= 4'd0;
            init_active <= 1'b1;
            low_phase   <= 1'b0;
            tmr_load    <= 1'b1;
            tmr_val     <= CNT_W'(C_PWR);
        end else begin
            tmr_load <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (tmr_done) state <= INIT;
                end
                INIT: begin
                    if (step == 4'd9) begin
                        state       <= IDLE;
                        init_active <= 1'b0;
                        busy_flag   <= 1'b0;
                        data_ready  <= 1'b1;
                    end else begin
                        cur_byte  <= init_byte(step);
                        rs        <= 1'b0;
                        d         <= hi_drive(init_byte(step));
                        two_nib   <= (BUS_WIDTH == 4) && (step >= 4'd4);
                        low_phase <= 1'b0;
                        post_val  <= init_wait(step);
                        // 8-bit mode has no 4-bit switch nibble
                        step      <= (step == 4'd2 && BUS_WIDTH == 8) ? 4'd4 : step + 4'd1;
                        state     <= SETUP;
                        tmr_load  <= 1'b1;
                        tmr_val   <= CNT_W'(C_SU);
                    end
                end
                IDLE: begin
                    if (data_valid) begin
                        cur_byte   <= d_in[7:0];
                        rs         <= d_in[8];
                        d          <= hi_drive(d_in[7:0]);
                        two_nib    <= (BUS_WIDTH == 4);
                        low_phase  <= 1'b0;
                        post_val   <= post_cycles(d_in[8], d_in[7:0]);
                        busy_flag  <= 1'b1;
                        data_ready <= 1'b0;
                        state      <= SETUP;
                        tmr_load   <= 1'b1;
                        tmr_val    <= CNT_W'(C_SU);
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        e        <= 1'b1;
                        state    <= E_HIGH;
                        tmr_load <= 1'b1;
                        tmr_val  <= CNT_W'(C_EH);
                    end
                end
                E_HIGH: begin
                    if (tmr_done) begin
                        e        <= 1'b0;
                        tmr_load <= 1'b1;
                        if (two_nib && !low_phase) begin
                            state   <= NIB_GAP;
                            tmr_val <= CNT_W'(C_NIB);
                        end else begin
                            state   <= POST_WAIT;
                            tmr_val <= post_val;
                        end
                    end
                end
                NIB_GAP: begin
                    if (tmr_done) begin
                        low_phase <= 1'b1;
                        d         <= {cur_byte[3:0], 4'h0};
                        state     <= SETUP;
                        tmr_load  <= 1'b1;
                        tmr_val   <= CNT_W'(C_SU);
                    end
                end
                POST_WAIT: begin
                    if (tmr_done) begin
                        if (init_active) begin
                            state <= INIT;
                        end else begin
                            state      <= IDLE;
                            busy_flag  <= 1'b0;
                            data_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= PWR_WAIT;
                    tmr_load <= 1'b1;
                    tmr_val  <= CNT_W'(C_PWR);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench: one 8-bit/2-line and one 4-bit/1-line driver at 1 MHz.
module tb_lcd_driver;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst8, rst4, dv8, dv4;
    logic [8:0] din8, din4;
    logic       rdy8, busy8, rs8, e8;
    logic       rdy4, busy4, rs4, e4;
    logic [7:0] d8, d4;

    lcd_driver #(.CLK_FREQ(1000000), .BUS_WIDTH(8), .NUM_LINES(2), .T_POWERUP_US(100)) dut8 (
        .clock(clock), .internal_reset(rst8), .d_in(din8), .data_valid(dv8),
        .data_ready(rdy8), .busy_flag(busy8), .rs(rs8), .e(e8), .d(d8));

    lcd_driver #(.CLK_FREQ(1000000), .BUS_WIDTH(4), .NUM_LINES(1), .T_POWERUP_US(100)) dut4 (
        .clock(clock), .internal_reset(rst4), .d_in(din4), .data_valid(dv4),
        .data_ready(rdy4), .busy_flag(busy4), .rs(rs4), .e(e4), .d(d4));

    int vectors     = 0;
    int miscompares = 0;

    int         cyc = 0;
    logic [8:0] w8[$];
    logic [8:0] w4[$];
    int         r8[$];
    int         f8_last   = 0;
    int         b8_fall   = 0;
    int         rdy8_rise = 0;
    logic       e8_q = 1'b0, e4_q = 1'b0, busy8_q = 1'b1, rdy8_q = 1'b0;

    // {rs,d} expected at each E pulse during init
    logic [8:0] exp8 [8]  = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
    // Rise-to-rise spacing: post wait + E high + INIT dispatch + SETUP
    int         gap8 [7]  = '{5003, 203, 203, 43, 43, 2003, 43};
    logic [8:0] exp4 [14] = '{9'h030, 9'h030, 9'h030, 9'h020,
                              9'h020, 9'h000, 9'h000, 9'h080, 9'h000, 9'h010,
                              9'h000, 9'h060, 9'h000, 9'h0C0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Pin monitor: logs E pulses and edges of busy/ready with a cycle stamp
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (e8 === 1'b1 && e8_q === 1'b0) begin
            w8.push_back({rs8, d8});
            r8.push_back(cyc);
        end
        if (e8 === 1'b0 && e8_q === 1'b1) f8_last = cyc;
        if (busy8 === 1'b0 && busy8_q === 1'b1) b8_fall = cyc;
        if (rdy8 === 1'b1 && rdy8_q === 1'b0) rdy8_rise = cyc;
        if (e4 === 1'b1 && e4_q === 1'b0) w4.push_back({rs4, d4});
        e8_q    = e8;
        busy8_q = busy8;
        rdy8_q  = rdy8;
        e4_q    = e4;
    end

    task automatic xfer(input logic [8:0] val, input int exp_wait, input string tag);
        int n;
        n = w8.size();
        din8 = val;
        dv8  = 1'b1;
        tick();
        dv8  = 1'b0;
        check_val({tag, "_busy"}, 32'({busy8, rdy8}), 32'b10);
        for (int i = 0; i < 3000 && rdy8 !== 1'b1; i++) tick();
        check_val({tag, "_count"}, 32'(w8.size()), 32'(n + 1));
        check_val({tag, "_pins"}, (w8.size() > n) ? 32'(w8[n]) : 32'hFFFF_FFFF, 32'(val));
        check_val({tag, "_wait"}, 32'(rdy8_rise - f8_last), 32'(exp_wait));
    endtask

    initial begin
        int t0;
        int n;
        rst8 = 1'b1; rst4 = 1'b1;
        dv8  = 1'b0; dv4  = 1'b0;
        din8 = 9'h000; din4 = 9'h000;
        repeat (3) tick();

        check_val("rst_e",     32'(e8), 32'd0);
        check_val("rst_rs",    32'(rs8), 32'd0);
        check_val("rst_d",     32'(d8), 32'h00);
        check_val("rst_busy",  32'(busy8), 32'd1);
        check_val("rst_ready", 32'(rdy8), 32'd0);
        check_val("rst_busy4", 32'({busy4, rdy4, e4}), 32'b100);

        rst8 = 1'b0; rst4 = 1'b0;
        t0 = cyc;
        // Valid during init must be ignored
        din8 = 9'h1AA; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        for (int i = 0; i < 9000 && (busy8 !== 1'b0 || busy4 !== 1'b0); i++) tick();
        check_val("init_done", 32'({busy8, busy4, rdy8, rdy4}), 32'b0011);

        // 8-bit init: pin values, first-pulse delay, spacing, busy fall
        check_val("init8_count", 32'(w8.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            check_val($sformatf("init8_w%0d", k), (k < w8.size()) ? 32'(w8[k]) : 32'hFFFF_FFFF, 32'(exp8[k]));
        check_val("init8_first_e", (r8.size() > 0) ? 32'(r8[0] - t0) : 32'hFFFF_FFFF, 32'd102);
        for (int k = 0; k < 7; k++)
            check_val($sformatf("init8_gap%0d", k), (k + 1 < r8.size()) ? 32'(r8[k+1] - r8[k]) : 32'hFFFF_FFFF, 32'(gap8[k]));
        check_val("init8_busy_fall", 32'(b8_fall - f8_last), 32'd41);

        // 4-bit init: nibble sequence on d[7:4]
        check_val("init4_count", 32'(w4.size()), 32'd14);
        for (int k = 0; k < 14; k++)
            check_val($sformatf("init4_w%0d", k), (k < w4.size()) ? 32'(w4[k]) : 32'hFFFF_FFFF, 32'(exp4[k]));

        // Transfers and their post waits
        xfer(9'h148, 40, "char_48");
        xfer(9'h001, 2000, "clear");
        xfer(9'h080, 40, "ddram");
        xfer(9'h002, 2000, "home");
        xfer(9'h00C, 40, "disp_on");

        // Valid held across a busy transfer: only the value present at ready is taken
        n = w8.size();
        din8 = 9'h155; dv8 = 1'b1;
        tick();
        din8 = 9'h141;
        for (int i = 0; i < 3000 && rdy8 !== 1'b1; i++) tick();
        tick();
        dv8 = 1'b0;
        check_val("held_busy", 32'({busy8, rdy8}), 32'b10);
        for (int i = 0; i < 3000 && rdy8 !== 1'b1; i++) tick();
        check_val("held_count", 32'(w8.size()), 32'(n + 2));
        check_val("held_first",  (w8.size() > n)     ? 32'(w8[n])     : 32'hFFFF_FFFF, 32'h155);
        check_val("held_second", (w8.size() > n + 1) ? 32'(w8[n + 1]) : 32'hFFFF_FFFF, 32'h141);

        // Reset while E is high aborts and restarts power-up
        din8 = 9'h148; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        for (int i = 0; i < 10 && e8 !== 1'b1; i++) tick();
        check_val("abort_e_seen", 32'(e8), 32'd1);
        rst8 = 1'b1;
        tick();
        check_val("abort_pins", 32'({e8, busy8, rdy8, rs8, d8}), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
        rst8 = 1'b0;
        t0 = cyc;
        n  = w8.size();
        for (int i = 0; i < 300 && w8.size() <= n; i++) tick();
        check_val("restart_w0", (w8.size() > n) ? 32'(w8[n]) : 32'hFFFF_FFFF, 32'h030);
        check_val("restart_first_e", (r8.size() > n) ? 32'(r8[n] - t0) : 32'hFFFF_FFFF, 32'd102);
        check_val("restart_busy", 32'({busy8, rdy8}), 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
